// File: rtl/lcd_spi_rx.sv
// Receive-side decoder for the 4-wire LCD serial link: rebuilds MSB-first bytes tagged
// with DC, flags aborted frames and classifies LCD_RST low pulses.
module lcd_spi_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned RST_MIN_CYCLES = 1048576
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LCD_SCK,
  input  logic       LCD_SDA,
  input  logic       LCD_DC,
  input  logic       LCD_CS,
  input  logic       LCD_RST,
  output logic [7:0] BYTE,
  output logic       BYTE_DC,
  output logic       BYTE_VALID,
  input  logic       BYTE_READY,
  output logic       OVERRUN,
  output logic       FRAME_ERR,
  output logic       RST_DONE,
  output logic       RST_SHORT
);

  localparam int unsigned CntW = $clog2(RST_MIN_CYCLES + 1);
  localparam logic [CntW-1:0] RstMin = CntW'(RST_MIN_CYCLES);

  typedef enum logic [1:0] {StIdle, StShift, StInReset} state_e;

  logic [SYNC_STAGES-1:0] sck_sync, sda_sync, dc_sync, cs_sync, rst_sync;
  logic                   sck_prev;
  logic                   sck_s, sda_s, dc_s, cs_s, rst_s, sck_rise;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [CntW-1:0] low_cnt_q, low_cnt_d;
  logic            done_q, done_d, done_dc_q, done_dc_d;
  logic            frame_err_q, frame_err_d;
  logic            rst_done_q, rst_done_d, rst_short_q, rst_short_d;
  logic            valid_q, valid_d, byte_dc_q, byte_dc_d, overrun_q, overrun_d;
  logic [7:0]      byte_q, byte_d;

  // Synchronizers preset to idle pin levels so reset release looks like an idle bus.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sck_sync <= '0;
      sda_sync <= '0;
      dc_sync  <= '0;
      cs_sync  <= '1;
      rst_sync <= '1;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], LCD_SCK};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], LCD_SDA};
      dc_sync  <= {dc_sync[SYNC_STAGES-2:0], LCD_DC};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], LCD_CS};
      rst_sync <= {rst_sync[SYNC_STAGES-2:0], LCD_RST};
      sck_prev <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign rst_s    = rst_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    low_cnt_d   = low_cnt_q;
    done_d      = 1'b0;
    done_dc_d   = done_dc_q;
    frame_err_d = 1'b0;
    rst_done_d  = 1'b0;
    rst_short_d = 1'b0;
    case (state_q)
      StIdle: begin
        bit_cnt_d = 3'd0;
        if (!rst_s) begin
          state_d   = StInReset;
          low_cnt_d = CntW'(1);
        end else if (!cs_s) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (!rst_s) begin
          state_d   = StInReset;
          bit_cnt_d = 3'd0;
          low_cnt_d = CntW'(1);
        end else begin
          if (sck_rise) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              done_d    = 1'b1;
              done_dc_d = dc_s;
            end
          end
          // Judged on the post-edge count so a final bit landing with CS rise still completes.
          if (cs_s) begin
            state_d     = StIdle;
            frame_err_d = (bit_cnt_d != 3'd0);
            bit_cnt_d   = 3'd0;
          end
        end
      end
      StInReset: begin
        bit_cnt_d = 3'd0;
        if (rst_s) begin
          if (low_cnt_q >= RstMin) rst_done_d = 1'b1;
          else rst_short_d = 1'b1;
          low_cnt_d = '0;
          state_d   = cs_s ? StIdle : StShift;
        end else if (low_cnt_q != RstMin) begin
          low_cnt_d = low_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    byte_d    = byte_q;
    byte_dc_d = byte_dc_q;
    overrun_d = overrun_q;
    if (valid_q && BYTE_READY) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || BYTE_READY) begin
        byte_d    = shreg_q;
        byte_dc_d = done_dc_q;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'd0;
      low_cnt_q   <= '0;
      done_q      <= 1'b0;
      done_dc_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rst_done_q  <= 1'b0;
      rst_short_q <= 1'b0;
      valid_q     <= 1'b0;
      byte_q      <= 8'd0;
      byte_dc_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      low_cnt_q   <= low_cnt_d;
      done_q      <= done_d;
      done_dc_q   <= done_dc_d;
      frame_err_q <= frame_err_d;
      rst_done_q  <= rst_done_d;
      rst_short_q <= rst_short_d;
      valid_q     <= valid_d;
      byte_q      <= byte_d;
      byte_dc_q   <= byte_dc_d;
      overrun_q   <= overrun_d;
    end
  end

  assign BYTE       = byte_q;
  assign BYTE_DC    = byte_dc_q;
  assign BYTE_VALID = valid_q;
  assign OVERRUN    = overrun_q;
  assign FRAME_ERR  = frame_err_q;
  assign RST_DONE   = rst_done_q;
  assign RST_SHORT  = rst_short_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Scoreboard bench for lcd_spi_rx: bytes queued on send, popped on DUT acceptance.
module tb_lcd_spi_rx;

  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned RST_MIN_CYCLES = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_sck = 1'b0, lcd_sda = 1'b0, lcd_dc = 1'b0, lcd_cs = 1'b1, lcd_rst = 1'b1;
  logic       byte_ready = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_dc, rx_valid, overrun, frame_err, rst_done, rst_short;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_rise = 0;
  int vcyc = 0, fe_cnt = 0, done_cnt = 0, short_cnt = 0;
  logic valid_prev = 1'b0;
  logic [8:0] sb[$];

  lcd_spi_rx #(.SYNC_STAGES(SYNC_STAGES), .RST_MIN_CYCLES(RST_MIN_CYCLES)) dut (
    .CLK(clk), .RESET(reset), .LCD_SCK(lcd_sck), .LCD_SDA(lcd_sda), .LCD_DC(lcd_dc),
    .LCD_CS(lcd_cs), .LCD_RST(lcd_rst), .BYTE(rx_byte), .BYTE_DC(rx_dc),
    .BYTE_VALID(rx_valid), .BYTE_READY(byte_ready), .OVERRUN(overrun),
    .FRAME_ERR(frame_err), .RST_DONE(rst_done), .RST_SHORT(rst_short)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: pulse counters, latency of each VALID rise, scoreboard pop on acceptance.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) vcyc++;
      if (frame_err) fe_cnt++;
      if (rst_done) done_cnt++;
      if (rst_short) short_cnt++;
      if (rx_valid && !valid_prev) check("latency", cyc - last_rise, SYNC_STAGES + 2);
      if (rx_valid && byte_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          logic [8:0] e;
          e = sb.pop_front();
          check("byte", rx_byte, e[7:0]);
          check("byte_dc", rx_dc, e[8]);
        end
      end
    end
    valid_prev = rx_valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    lcd_sda = b;
    lcd_sck = 1'b0;
    wait_cycles(4);
    lcd_sck = 1'b1;
    last_rise = cyc;
    wait_cycles(4);
    lcd_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc, input logic expect_out);
    lcd_dc = dc;
    if (expect_out) sb.push_back({dc, b});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_cycles(4);
  endtask

  task automatic cs_low();
    lcd_cs = 1'b0;
    wait_cycles(4);
  endtask

  task automatic cs_high();
    wait_cycles(2);
    lcd_cs = 1'b1;
    wait_cycles(8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, d0, s0;
    logic [12:0] acc;

    // Reset and idle bus: everything stays 0.
    wait_cycles(3);
    check("reset_valid", rx_valid, 0);
    reset = 1'b0;
    acc = '0;
    for (int i = 0; i < 100; i++) begin
      wait_cycles(1);
      acc |= {rx_byte, rx_dc, rx_valid, overrun, frame_err, rst_done | rst_short};
    end
    check("idle_outputs", 32'(acc), 0);

    // Single byte, ready high: one-cycle valid.
    byte_ready = 1'b1;
    v0 = vcyc;
    cs_low();
    send_byte(8'hA5, 1'b0, 1'b1);
    cs_high();
    check("a5_valid_cycles", vcyc - v0, 1);
    check("a5_sb_drained", sb.size(), 0);

    // Three bytes in one frame with DC switching.
    v0 = vcyc; f0 = fe_cnt;
    cs_low();
    send_byte(8'h2A, 1'b0, 1'b1);
    send_byte(8'h00, 1'b1, 1'b1);
    send_byte(8'h7F, 1'b1, 1'b1);
    cs_high();
    check("frame3_valid_cycles", vcyc - v0, 3);
    check("frame3_no_fe", fe_cnt - f0, 0);
    check("frame3_no_overrun", overrun, 0);
    check("frame3_sb_drained", sb.size(), 0);

    // Overrun: second byte dropped while first is held.
    byte_ready = 1'b0;
    cs_low();
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h22, 1'b1, 1'b0);
    cs_high();
    check("ovr_byte_held", rx_byte, 8'h11);
    check("ovr_dc_held", rx_dc, 0);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_flag", overrun, 1);
    byte_ready = 1'b1;
    wait_cycles(1);
    check("ovr_valid_drop", rx_valid, 0);
    check("ovr_byte_after", rx_byte, 8'h11);
    check("ovr_sticky", overrun, 1);
    check("ovr_sb_drained", sb.size(), 0);

    // Aborted frame after 5 bits, then a clean byte.
    v0 = vcyc; f0 = fe_cnt;
    cs_low();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cs_high();
    check("fe_pulse_count", fe_cnt - f0, 1);
    check("fe_no_valid", vcyc - v0, 0);
    v0 = vcyc;
    cs_low();
    send_byte(8'h3C, 1'b0, 1'b1);
    cs_high();
    check("after_fe_valid", vcyc - v0, 1);

    // Long LCD_RST pulse counts as a valid reset.
    d0 = done_cnt; s0 = short_cnt;
    lcd_rst = 1'b0;
    wait_cycles(100);
    lcd_rst = 1'b1;
    wait_cycles(10);
    check("rst_long_done", done_cnt - d0, 1);
    check("rst_long_short", short_cnt - s0, 0);

    // Short glitch.
    d0 = done_cnt; s0 = short_cnt;
    lcd_rst = 1'b0;
    wait_cycles(10);
    lcd_rst = 1'b1;
    wait_cycles(10);
    check("rst_glitch_short", short_cnt - s0, 1);
    check("rst_glitch_done", done_cnt - d0, 0);

    // Reset mid-byte: partial byte dropped silently, next byte clean.
    v0 = vcyc; f0 = fe_cnt; d0 = done_cnt;
    cs_low();
    lcd_dc = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    lcd_rst = 1'b0;
    wait_cycles(100);
    lcd_rst = 1'b1;
    wait_cycles(8);
    send_byte(8'h96, 1'b1, 1'b1);
    cs_high();
    check("midrst_no_fe", fe_cnt - f0, 0);
    check("midrst_one_byte", vcyc - v0, 1);
    check("midrst_done", done_cnt - d0, 1);

    // Asynchronous RESET while a byte is held and OVERRUN is set.
    byte_ready = 1'b0;
    cs_low();
    send_byte(8'h44, 1'b0, 1'b1);
    send_byte(8'h55, 1'b0, 1'b0);
    cs_high();
    check("pre_rst_valid", rx_valid, 1);
    check("pre_rst_overrun", overrun, 1);
    reset = 1'b1;
    #2;
    check("async_valid", rx_valid, 0);
    check("async_overrun", overrun, 0);
    check("async_byte", rx_byte, 0);
    sb.delete();
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(4);
    byte_ready = 1'b1;
    v0 = vcyc;
    cs_low();
    send_byte(8'h5A, 1'b1, 1'b1);
    cs_high();
    check("post_rst_valid", vcyc - v0, 1);
    check("post_rst_sb_drained", sb.size(), 0);
    check("post_rst_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_spi_rx.md
Name: lcd_spi_rx

Overview:
- Receive-side decoder for the 4-wire LCD serial interface (SCK, SDA, DC, CS, plus RST) driven by the board's LCD controller logic.
- Samples the pins on the system clock and reassembles MSB-first bytes, each tagged with its DC level.
- Classifies LCD_RST low pulses as a valid hardware reset or a short glitch.
- Used as an on-chip loopback monitor and as the bench-side LCD model for controller verification.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on every LCD_* input (≥2).
- RST_MIN_CYCLES, 1048576, minimum synchronized LCD_RST low width, in CLK cycles, that counts as a valid reset.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RESET  input  1  asynchronous, active-high block reset.
- LCD_SCK  input  1  serial clock; data sampled on its rising edge (mode 0).
- LCD_SDA  input  1  serial data, MSB first.
- LCD_DC  input  1  data/command select; 0 = command, 1 = data.
- LCD_CS  input  1  chip select, active low.
- LCD_RST  input  1  LCD hardware reset, active low.
- BYTE  output  8  received byte.
- BYTE_DC  output  1  DC level captured with bit 0 (last bit) of BYTE.
- BYTE_VALID  output  1  BYTE and BYTE_DC valid; held until accepted.
- BYTE_READY  input  1  consumer accepts when high together with BYTE_VALID.
- OVERRUN  output  1  sticky; a byte was dropped.
- FRAME_ERR  output  1  one-cycle pulse; CS deasserted mid-byte.
- RST_DONE  output  1  one-cycle pulse; valid reset pulse ended.
- RST_SHORT  output  1  one-cycle pulse; LCD_RST low pulse shorter than RST_MIN_CYCLES.

Behaviour:
- Reset values:
  - RESET high clears all outputs to 0, bit counter to 0, shift register to 0, low counter to 0, state to IDLE.
  - Synchronizer flops preset to idle pin levels: SCK=0, SDA=0, DC=0, CS=1, RST=1.
- Reset mid-operation: partial byte, pending BYTE_VALID and OVERRUN are all discarded; no pulses are emitted.
- Inputs: each LCD_* pin passes through SYNC_STAGES flops. A one-flop-delayed copy of synchronized SCK provides rising-edge detection.
- Clock ratio: CLK must be ≥4× SCK frequency; SCK high and low phases must each last ≥2 CLK cycles.
- States:
  - IDLE: CS high. Bit counter held at 0.
    - Synchronized CS falling → SHIFT.
    - Synchronized RST low → IN_RESET.
  - SHIFT: on each synchronized SCK rising edge, shift SDA into the LSB and increment bit counter (3-bit, wraps 7→0).
    - On the 8th edge, the completed byte and the current synchronized DC go to the output stage; counter returns to 0 and state stays SHIFT.
    - CS rising → IDLE. If the bit counter is nonzero, pulse FRAME_ERR for 1 cycle and drop the partial byte.
    - RST low → IN_RESET.
  - IN_RESET: decoder frozen, bit counter cleared, SCK edges ignored.
    - Low counter increments each cycle, saturating at RST_MIN_CYCLES; width is clog2(RST_MIN_CYCLES+1).
    - On synchronized RST rising: pulse RST_DONE if count ≥ RST_MIN_CYCLES, else pulse RST_SHORT. Clear the counter, then go to SHIFT if CS is low, else IDLE.
- Priority within one cycle: RST low > SCK edge > CS rise.
  - RST falling mid-byte: partial byte dropped, no FRAME_ERR.
  - 8th SCK edge and CS rise detected in the same cycle: byte completes, no FRAME_ERR.
- Latency: BYTE_VALID rises on the CLK edge SYNC_STAGES+2 cycles after the raw SCK rising edge that delivers the 8th bit.
- Output stage:
  - BYTE_VALID stays high until a cycle with BYTE_READY=1; it drops on the next edge.
  - If a new byte completes in that same acceptance cycle, the new byte loads and BYTE_VALID stays high.
  - If a new byte completes while BYTE_VALID=1 and BYTE_READY=0: the new byte is discarded, BYTE/BYTE_DC keep the old value, OVERRUN sets. OVERRUN is cleared only by RESET.
  - BYTE/BYTE_DC change only when loaded.

Test Plan:
- RESET pulse, pins idle → all outputs 0 for 100 cycles. With BYTE_READY=1, send 0xA5 with DC=0 at CLK/8 → BYTE=0xA5, BYTE_DC=0, BYTE_VALID high exactly 1 cycle, at SYNC_STAGES+2 cycles after the 8th SCK rise.
- One CS-low frame carrying 0x2A (DC=0) then 0x00,0x7F (DC=1), READY=1 → three valid cycles in order: (0x2A,0), (0x00,1), (0x7F,1). No FRAME_ERR, no OVERRUN.
- READY=0, send 0x11 then 0x22 → BYTE stays 0x11 with VALID held and OVERRUN=1. Raise READY → VALID drops next cycle, BYTE still 0x11.
- Send 5 bits, then raise CS → FRAME_ERR single-cycle pulse, no BYTE_VALID. Next full byte 0x3C decodes correctly.
- RST_MIN_CYCLES=64: LCD_RST low 100 cycles → RST_DONE pulse. LCD_RST low 10 cycles → RST_SHORT pulse. LCD_RST low during bit 4 of a byte → no FRAME_ERR and no byte; next byte after release decodes cleanly.
- Assert RESET while BYTE_VALID=1 and OVERRUN=1 → both 0 immediately (asynchronous). A subsequent byte decodes normally.
